// File: rtl/xy_route_unit.sv
// ---------------------------------------------------------------------------
// xy_route_unit
// Single-input XY routing stage for a wormhole NoC router. The head flit at
// the front of the upstream buffer is decoded for its destination, a one-hot
// output-port request is raised, and once the allocator grants it the whole
// packet is streamed out one flit per cycle. Flow is paced by the upstream
// buffer occupancy, the downstream on/off signal and the grant.
//
// Optional feature: define PKT_CNT_EN to add pkt_cnt_o, a 16-bit wrapping
// count of TAIL/HEADTAIL pops. With the macro undefined the port and counter
// do not exist.
//
// Handshake: a flit is transferred from the upstream buffer on every rising
// clk edge where buf_read_o=1; buf_read_o is only ever asserted while
// buf_empty_i=0, so a pop always removes a real flit. A forwarded flit is
// presented on flit_o with flit_valid_o=1 for exactly the cycle after its pop.
// ---------------------------------------------------------------------------
module xy_route_unit #(
    parameter int FLIT_W  = 32,
    parameter int COORD_W = 4,
    parameter int CUR_X   = 0,
    parameter int CUR_Y   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] flit_i,
    input  logic              buf_empty_i,
    output logic              buf_read_o,
    output logic [4:0]        out_req_o,
    input  logic              out_grant_i,
    input  logic              on_off_i,
    output logic [FLIT_W-1:0] flit_o,
    output logic              flit_valid_o,
    output logic              proto_err_o,
`ifdef PKT_CNT_EN
    output logic [15:0]       pkt_cnt_o,
`endif
    output logic [1:0]        dbg_state_o
);

    // Router position as COORD_W-wide unsigned values for the compare.
    localparam logic [COORD_W-1:0] LP_CUR_X = COORD_W'(CUR_X);
    localparam logic [COORD_W-1:0] LP_CUR_Y = COORD_W'(CUR_Y);

    // Flit type encodings in the two most significant bits.
    localparam logic [1:0] LP_HEAD     = 2'b00;
    localparam logic [1:0] LP_BODY     = 2'b01;
    localparam logic [1:0] LP_TAIL     = 2'b10;
    localparam logic [1:0] LP_HEADTAIL = 2'b11;

    // One-hot output port encodings.
    localparam logic [4:0] LP_PORT_L = 5'b00001;
    localparam logic [4:0] LP_PORT_N = 5'b00010;
    localparam logic [4:0] LP_PORT_E = 5'b00100;
    localparam logic [4:0] LP_PORT_S = 5'b01000;
    localparam logic [4:0] LP_PORT_W = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_FORWARD = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [4:0]           r_route;
    logic                 r_first;
    logic [FLIT_W-1:0]    r_flit;
    logic                 r_flit_valid;
    logic                 r_proto_err;

    logic [1:0]           w_type;
    logic [COORD_W-1:0]   w_dest_x;
    logic [COORD_W-1:0]   w_dest_y;
    logic                 w_starts_pkt;
    logic                 w_ends_pkt;
    logic                 w_is_head;
    logic [4:0]           w_route;
    logic                 w_pop;
    logic                 w_idle_pop;
    logic                 w_fwd_pop;
    logic                 w_latch_route;
    logic [4:0]           w_out_req;

    // Field decode of the flit at the head of the upstream buffer.
    always_comb begin
        w_type       = flit_i[FLIT_W-1 -: 2];
        w_dest_x     = flit_i[2*COORD_W-1 -: COORD_W];
        w_dest_y     = flit_i[COORD_W-1:0];
        w_starts_pkt = (w_type == LP_HEAD) || (w_type == LP_HEADTAIL);
        w_ends_pkt   = (w_type == LP_TAIL) || (w_type == LP_HEADTAIL);
        w_is_head    = (w_type == LP_HEAD);
    end

    // Dimension-ordered route: resolve X first, then Y, else deliver locally.
    always_comb begin
        w_route = LP_PORT_L;
        if (w_dest_x > LP_CUR_X) begin
            w_route = LP_PORT_E;
        end else if (w_dest_x < LP_CUR_X) begin
            w_route = LP_PORT_W;
        end else if (w_dest_y > LP_CUR_Y) begin
            w_route = LP_PORT_N;
        end else if (w_dest_y < LP_CUR_Y) begin
            w_route = LP_PORT_S;
        end
    end

    // State register; reset abandons any packet in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!buf_empty_i && w_starts_pkt) begin
                    w_next_state = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (out_grant_i) begin
                    w_next_state = ST_FORWARD;
                end
            end
            ST_FORWARD: begin
                if (w_fwd_pop && w_ends_pkt) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Output/strobe logic: pop qualification and the held port request.
    always_comb begin
        w_idle_pop    = 1'b0;
        w_fwd_pop     = 1'b0;
        w_latch_route = 1'b0;
        w_out_req     = 5'b00000;
        case (r_state)
            ST_IDLE: begin
                // A stray BODY/TAIL at packet boundary is drained and dropped.
                w_idle_pop    = !rst && !buf_empty_i && !w_starts_pkt;
                w_latch_route = !buf_empty_i && w_starts_pkt;
            end
            ST_REQUEST: begin
                w_out_req = r_route;
            end
            ST_FORWARD: begin
                w_out_req = r_route;
                w_fwd_pop = !rst && !buf_empty_i && on_off_i && out_grant_i;
            end
            default: begin
                w_out_req = 5'b00000;
            end
        endcase
        w_pop = w_idle_pop || w_fwd_pop;
    end

    // Route is captured when a packet head is accepted in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_route <= 5'b00000;
        end else if (w_latch_route) begin
            r_route <= w_route;
        end
    end

    // Marks that the next FORWARD pop is the packet's own head flit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first <= 1'b0;
        end else if (r_state == ST_REQUEST && out_grant_i) begin
            r_first <= 1'b1;
        end else if (w_fwd_pop) begin
            r_first <= 1'b0;
        end
    end

    // Output flit register: loads on each forwarded pop, holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flit       <= '0;
            r_flit_valid <= 1'b0;
        end else begin
            r_flit_valid <= w_fwd_pop;
            if (w_fwd_pop) begin
                r_flit <= flit_i;
            end
        end
    end

    // Sticky error: orphan BODY/TAIL in IDLE, or a second HEAD inside a packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_proto_err <= 1'b0;
        end else if (w_idle_pop || (w_fwd_pop && w_is_head && !r_first)) begin
            r_proto_err <= 1'b1;
        end
    end

`ifdef PKT_CNT_EN
    logic [15:0] r_pkt_cnt;

    // Counts every popped packet terminator; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_cnt <= 16'd0;
        end else if (w_pop && w_ends_pkt) begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
    end

    assign pkt_cnt_o = r_pkt_cnt;
`endif

    assign buf_read_o   = w_pop;
    assign out_req_o    = w_out_req;
    assign flit_o       = r_flit;
    assign flit_valid_o = r_flit_valid;
    assign proto_err_o  = r_proto_err;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_xy_route_unit.sv
// ---------------------------------------------------------------------------
// tb_xy_route_unit
// Directed bench for xy_route_unit at router position (1,1). An upstream
// buffer model feeds flits from in_q and pops on buf_read_o; forwarded flits
// are pushed to exp_q when issued and a monitor pops/compares on every
// flit_valid_o cycle. Timing: posedge at 10k+5, buffer inputs change at the
// negedge, the pop strobe is sampled 1 before the posedge, the monitor
// samples 1 after it and the main sequence acts 2 after it.
// ---------------------------------------------------------------------------
module tb_xy_route_unit;
    localparam int FW = 32;
    localparam int CW = 4;

    localparam logic [1:0] T_HEAD     = 2'b00;
    localparam logic [1:0] T_BODY     = 2'b01;
    localparam logic [1:0] T_TAIL     = 2'b10;
    localparam logic [1:0] T_HEADTAIL = 2'b11;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQUEST = 2'd1;
    localparam logic [1:0] S_FORWARD = 2'd2;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] flit_i;
    logic          buf_empty_i;
    logic          buf_read_o;
    logic [4:0]    out_req_o;
    logic          out_grant_i;
    logic          on_off_i;
    logic [FW-1:0] flit_o;
    logic          flit_valid_o;
    logic          proto_err_o;
    logic [1:0]    dbg_state_o;
`ifdef PKT_CNT_EN
    logic [15:0]   pkt_cnt_o;
`endif

    logic [FW-1:0] in_q[$];
    logic [FW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            pop_cnt = 0;
    bit            pending = 1'b0;
    int            base;

    xy_route_unit #(
        .FLIT_W (FW),
        .COORD_W(CW),
        .CUR_X  (1),
        .CUR_Y  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flit_i      (flit_i),
        .buf_empty_i (buf_empty_i),
        .buf_read_o  (buf_read_o),
        .out_req_o   (out_req_o),
        .out_grant_i (out_grant_i),
        .on_off_i    (on_off_i),
        .flit_o      (flit_o),
        .flit_valid_o(flit_valid_o),
        .proto_err_o (proto_err_o),
`ifdef PKT_CNT_EN
        .pkt_cnt_o   (pkt_cnt_o),
`endif
        .dbg_state_o (dbg_state_o)
    );

    // Clock/reset block.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [21:0] p,
                                         input logic [3:0] x, input logic [3:0] y);
        return {t, p, x, y};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_pops(input string name, input int target, input int budget);
        int k = 0;
        while (pop_cnt < target && k < budget) begin
            cyc(1);
            k++;
        end
        check(name, pop_cnt, target);
    endtask

    task automatic wait_state(input string name, input logic [1:0] st, input int budget);
        int k = 0;
        while (dbg_state_o !== st && k < budget) begin
            cyc(1);
            k++;
        end
        check(name, dbg_state_o, st);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (!(in_q.size() == 0 && exp_q.size() == 0 && dbg_state_o == S_IDLE &&
                 !flit_valid_o) && k < budget) begin
            cyc(1);
            k++;
        end
        check(name, (in_q.size() == 0 && exp_q.size() == 0 && dbg_state_o == S_IDLE), 1);
    endtask

    task automatic send(input logic [FW-1:0] f, input bit expect_out);
        in_q.push_back(f);
        if (expect_out) exp_q.push_back(f);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_req"}, out_req_o, 5'b00000);
        check({tag, "_flit_o"}, flit_o, 0);
        check({tag, "_flit_valid"}, flit_valid_o, 0);
        check({tag, "_proto_err"}, proto_err_o, 0);
        check({tag, "_buf_read"}, buf_read_o, 0);
        check({tag, "_state"}, dbg_state_o, S_IDLE);
    endtask

    // Upstream buffer model: presents the queue head, pops on a sampled strobe.
    initial begin
        flit_i      = '0;
        buf_empty_i = 1'b1;
        forever begin
            @(negedge clk);
            if (pending && in_q.size() > 0) in_q.delete(0);
            if (in_q.size() > 0) begin
                flit_i      = in_q[0];
                buf_empty_i = 1'b0;
            end else begin
                flit_i      = '0;
                buf_empty_i = 1'b1;
            end
            #4;
            check("pop_while_empty", {31'd0, buf_read_o & buf_empty_i}, 0);
            pending = buf_read_o && !rst;
            if (pending) pop_cnt++;
        end
    end

    // Scoreboard monitor: every valid output flit must match the next expected.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (flit_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_flit", flit_o, 32'hDEAD_0000);
                end else begin
                    check("flit_data", flit_o, exp_q.pop_front());
                end
            end
        end
    end

    // Directed sequence.
    initial begin
        rst         = 1'b1;
        on_off_i    = 1'b1;
        out_grant_i = 1'b1;
        cyc(1);
        check_reset_outputs("reset");
        rst = 1'b0;
        cyc(1);

        // HEADTAIL to (3,1): East request one cycle after arrival, single pop.
        base = pop_cnt;
        send(mk(T_HEADTAIL, 22'h1A5A5, 4'd3, 4'd1), 1'b1);
        cyc(1);
        check("ht_east_req", out_req_o, 5'b00100);
        check("ht_state_req", dbg_state_o, S_REQUEST);
        check("ht_no_pop_req", pop_cnt, base);
        cyc(1);
        check("ht_state_fwd", dbg_state_o, S_FORWARD);
        check("ht_pop_strobe", buf_read_o, 1);
        cyc(1);
        check("ht_state_idle", dbg_state_o, S_IDLE);
        check("ht_req_clear", out_req_o, 5'b00000);
        check("ht_one_pop", pop_cnt, base + 1);
        check("ht_valid_lat", flit_valid_o, 1);
        cyc(1);
        check("ht_valid_one", flit_valid_o, 0);
        wait_drain("ht_drain", 10);

        // HEADTAIL to (1,3): North.
        send(mk(T_HEADTAIL, 22'h00777, 4'd1, 4'd3), 1'b1);
        wait_state("north_wait", S_REQUEST, 10);
        check("north_req", out_req_o, 5'b00010);
        wait_drain("north_drain", 10);

        // 4-flit packet to (1,0): South, downstream off for 3 cycles mid-packet.
        base = pop_cnt;
        send(mk(T_HEAD, 22'h00011, 4'd1, 4'd0), 1'b1);
        send(mk(T_BODY, 22'h00022, 4'd1, 4'd0), 1'b1);
        send(mk(T_BODY, 22'h00033, 4'd1, 4'd0), 1'b1);
        send(mk(T_TAIL, 22'h00044, 4'd1, 4'd0), 1'b1);
        wait_pops("south_two_pops", base + 2, 20);
        on_off_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("south_req_held", out_req_o, 5'b01000);
            check("south_no_pop_off", buf_read_o, 0);
        end
        check("south_pops_frozen", pop_cnt, base + 2);
        on_off_i = 1'b1;
        cyc(1);
        check("south_req_resume", out_req_o, 5'b01000);
        wait_drain("south_drain", 30);
        check("south_total_pops", pop_cnt, base + 4);

        // Packet to (1,1): Local, grant withheld for 5 cycles.
        out_grant_i = 1'b0;
        send(mk(T_HEAD, 22'h00055, 4'd1, 4'd1), 1'b1);
        send(mk(T_TAIL, 22'h00066, 4'd1, 4'd1), 1'b1);
        wait_state("local_wait", S_REQUEST, 10);
        base = pop_cnt;
        for (int i = 0; i < 5; i++) begin
            check("local_req_held", out_req_o, 5'b00001);
            check("local_no_pop", buf_read_o, 0);
            cyc(1);
        end
        check("local_pops_frozen", pop_cnt, base);
        out_grant_i = 1'b1;
        wait_drain("local_drain", 20);
        check("local_total_pops", pop_cnt, base + 2);
        check("no_err_so_far", proto_err_o, 0);
`ifdef PKT_CNT_EN
        check("pkt_cnt_four", pkt_cnt_o, 4);
`endif

        // Packet to (0,1): West, with a stray HEAD mid-packet forwarded as body.
        base = pop_cnt;
        send(mk(T_HEAD, 22'h00101, 4'd0, 4'd1), 1'b1);
        send(mk(T_BODY, 22'h00202, 4'd0, 4'd1), 1'b1);
        send(mk(T_HEAD, 22'h00303, 4'd2, 4'd2), 1'b1);
        send(mk(T_TAIL, 22'h00404, 4'd0, 4'd1), 1'b1);
        wait_pops("west_three_pops", base + 3, 20);
        check("west_req", out_req_o, 5'b10000);
        check("west_mid_head_err", proto_err_o, 1);
        check("west_still_fwd", dbg_state_o, S_FORWARD);
        wait_drain("west_drain", 20);

        rst = 1'b1;
        cyc(1);
        check("err_cleared", proto_err_o, 0);
        rst = 1'b0;
        cyc(1);

        // Orphan BODY at IDLE: popped, dropped, sticky error.
        base = pop_cnt;
        send(mk(T_BODY, 22'h00BAD, 4'd3, 4'd3), 1'b0);
        wait_drain("orphan_drain", 10);
        check("orphan_popped", pop_cnt, base + 1);
        check("orphan_err", proto_err_o, 1);
        cyc(5);
        check("orphan_err_sticky", proto_err_o, 1);
        check("orphan_idle", dbg_state_o, S_IDLE);

        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(1);

        // Reset after 2 of 4 flits to (2,2): packet abandoned, rest flagged.
        base = pop_cnt;
        send(mk(T_HEAD, 22'h00A01, 4'd2, 4'd2), 1'b1);
        send(mk(T_BODY, 22'h00A02, 4'd2, 4'd2), 1'b1);
        send(mk(T_BODY, 22'h00A03, 4'd2, 4'd2), 1'b0);
        send(mk(T_TAIL, 22'h00A04, 4'd2, 4'd2), 1'b0);
        wait_pops("abort_two_pops", base + 2, 20);
        check("abort_req_before", out_req_o, 5'b00100);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        cyc(1);
        rst = 1'b0;
        wait_drain("abort_drain", 20);
        check("abort_total_pops", pop_cnt, base + 4);
        check("abort_err", proto_err_o, 1);
        check("abort_idle", dbg_state_o, S_IDLE);

        cyc(3);
        check("exp_q_empty", exp_q.size(), 0);
        check("in_q_empty", in_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
